accel_sched: RTL and testbench

Command scheduler between the decode stage and the three crypto engines (hash, encrypt, decrypt). It queues accelerator commands raised by decode's H_int/E_int/D_int with their 11-bit index, and dispatches each to its engine when that engine is idle. It arbitrates the engines' shared data-memory port round-robin and returns single-cycle H_done/E_done/D_done pulses to decode. It also produces the stall that holds decode while the command queue is full.

---
 rtl/accel_sched.sv | 235 +++++++++++++++++++++++
 tb/tb_accel_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_sched.sv
// Queues H/E/D accelerator commands from decode, dispatches in order to idle engines, round-robins the engines' memory port.
// Latency: request queued on the sampling edge, start one edge later; done one edge after fin; grant on the request edge.
// Backpressure: cmd_stall is high while the command queue is full; requests seen during stall are dropped and re-presented by decode.
module accel_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             H_int,
    input  logic             E_int,
    input  logic             D_int,
    input  logic [IDX_W-1:0] index,
    output logic             cmd_stall,
    output logic             h_start,
    output logic             e_start,
    output logic             d_start,
    output logic [IDX_W-1:0] eng_index,
    input  logic             h_fin,
    input  logic             e_fin,
    input  logic             d_fin,
    input  logic             h_mreq,
    input  logic             e_mreq,
    input  logic             d_mreq,
    output logic             h_mgnt,
    output logic             e_mgnt,
    output logic             d_mgnt,
    output logic             H_done,
    output logic             E_done,
    output logic             D_done,
    output logic             busy,
    output logic             cmd_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] T_H = 2'd0;
    localparam logic [1:0] T_E = 2'd1;
    localparam logic [1:0] T_D = 2'd2;

    typedef struct packed {
        logic [1:0]       typ;
        logic [IDX_W-1:0] idx;
    } cmd_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT_H,
        ARB_GNT_E,
        ARB_GNT_D
    } arb_state_t;

    // command queue storage and control
    cmd_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_stall;

    // engine tracking and registered outputs (bit 0 = H, 1 = E, 2 = D)
    logic [2:0]       r_eng_busy;
    logic [2:0]       r_start;
    logic [2:0]       r_done;
    logic [IDX_W-1:0] r_eng_index;
    logic             r_busy;
    logic             r_err;

    // memory-port arbiter
    arb_state_t       r_arb_state;
    arb_state_t       w_arb_nxt;
    logic [1:0]       r_last;
    logic [1:0]       w_last_nxt;
    logic [2:0]       r_mgnt;
    logic [2:0]       w_gnt_nxt;

    logic [2:0]       w_req;
    logic             w_multi;
    logic             w_push;
    cmd_t             w_push_cmd;
    cmd_t             w_head;
    logic             w_head_busy;
    logic             w_pop;
    logic [2:0]       w_start_vec;
    logic [2:0]       w_fin;
    logic [2:0]       w_done;
    logic [2:0]       w_busy_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [3:0]       w_mreq4;
    logic             w_keep;
    logic [1:0]       w_o0;
    logic [1:0]       w_o1;
    logic [1:0]       w_o2;

    // Decode the incoming request: H beats E beats D, extra bits flag an error.
    always_comb begin
        w_req          = {D_int, E_int, H_int};
        w_multi        = (H_int & E_int) | (H_int & D_int) | (E_int & D_int);
        w_push         = (|w_req) & ~r_stall;
        w_push_cmd.idx = index;
        if (H_int)      w_push_cmd.typ = T_H;
        else if (E_int) w_push_cmd.typ = T_E;
        else            w_push_cmd.typ = T_D;
    end

    // Head-of-line dispatch: pop only when the head's own engine is idle.
    always_comb begin
        w_head      = r_mem[r_rptr];
        w_start_vec = 3'b000;
        case (w_head.typ)
            T_H:     w_head_busy = r_eng_busy[0];
            T_E:     w_head_busy = r_eng_busy[1];
            default: w_head_busy = r_eng_busy[2];
        endcase
        w_pop = (r_count != '0) & ~w_head_busy;
        if (w_pop) begin
            case (w_head.typ)
                T_H:     w_start_vec = 3'b001;
                T_E:     w_start_vec = 3'b010;
                default: w_start_vec = 3'b100;
            endcase
        end
        w_fin       = {d_fin, e_fin, h_fin};
        // a fin on an idle engine is ignored; start and fin never hit the same busy engine
        w_done      = w_fin & r_eng_busy;
        w_busy_nxt  = (r_eng_busy & ~w_fin) | w_start_vec;
        w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    // Queue payload write; storage needs no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_push_cmd;
    end

    // Queue pointers, occupancy and the registered full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_stall <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_stall <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
        end
    end

    // Engine busy flags plus start/done/error/busy output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eng_busy  <= 3'b000;
            r_start     <= 3'b000;
            r_done      <= 3'b000;
            r_eng_index <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_eng_busy <= w_busy_nxt;
            r_start    <= w_start_vec;
            r_done     <= w_done;
            r_err      <= w_multi;
            r_busy     <= (w_count_nxt != '0) | (|w_busy_nxt);
            if (w_pop) r_eng_index <= w_head.idx;
        end
    end

    // Arbiter next state: hold while the owner requests, otherwise hand to the next requester after the last owner.
    always_comb begin
        w_arb_nxt  = r_arb_state;
        w_last_nxt = r_last;
        w_gnt_nxt  = 3'b000;
        w_mreq4    = {1'b0, d_mreq, e_mreq, h_mreq};
        case (r_arb_state)
            ARB_GNT_H: w_keep = h_mreq;
            ARB_GNT_E: w_keep = e_mreq;
            ARB_GNT_D: w_keep = d_mreq;
            default:   w_keep = 1'b0;
        endcase
        case (r_last)
            2'd0:    begin w_o0 = 2'd1; w_o1 = 2'd2; w_o2 = 2'd0; end
            2'd1:    begin w_o0 = 2'd2; w_o1 = 2'd0; w_o2 = 2'd1; end
            default: begin w_o0 = 2'd0; w_o1 = 2'd1; w_o2 = 2'd2; end
        endcase
        if (!w_keep) begin
            // the current owner is always w_o2 and has dropped, so it is skipped naturally
            w_arb_nxt = ARB_IDLE;
            if (w_mreq4[w_o0])      w_last_nxt = w_o0;
            else if (w_mreq4[w_o1]) w_last_nxt = w_o1;
            else if (w_mreq4[w_o2]) w_last_nxt = w_o2;
            if (w_mreq4[w_o0] | w_mreq4[w_o1] | w_mreq4[w_o2]) begin
                case (w_last_nxt)
                    2'd0:    w_arb_nxt = ARB_GNT_H;
                    2'd1:    w_arb_nxt = ARB_GNT_E;
                    default: w_arb_nxt = ARB_GNT_D;
                endcase
            end
        end
        case (w_arb_nxt)
            ARB_GNT_H: w_gnt_nxt = 3'b001;
            ARB_GNT_E: w_gnt_nxt = 3'b010;
            ARB_GNT_D: w_gnt_nxt = 3'b100;
            default:   w_gnt_nxt = 3'b000;
        endcase
    end

    // Arbiter state, round-robin pointer (starts at D so H is first) and registered grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arb_state <= ARB_IDLE;
            r_last      <= 2'd2;
            r_mgnt      <= 3'b000;
        end else begin
            r_arb_state <= w_arb_nxt;
            r_last      <= w_last_nxt;
            r_mgnt      <= w_gnt_nxt;
        end
    end

    assign cmd_stall = r_stall;
    assign h_start   = r_start[0];
    assign e_start   = r_start[1];
    assign d_start   = r_start[2];
    assign eng_index = r_eng_index;
    assign H_done    = r_done[0];
    assign E_done    = r_done[1];
    assign D_done    = r_done[2];
    assign h_mgnt    = r_mgnt[0];
    assign e_mgnt    = r_mgnt[1];
    assign d_mgnt    = r_mgnt[2];
    assign busy      = r_busy;
    assign cmd_err   = r_err;

endmodule

// File: tb/tb_accel_sched.sv
// Bench for accel_sched: directed scenarios plus random traffic, every cycle compared with a queue-based reference model.
module tb_accel_sched;

    localparam int DEPTH = 4;
    localparam int IDX_W = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             H_int = 0, E_int = 0, D_int = 0;
    logic [IDX_W-1:0] index = '0;
    logic             h_fin = 0, e_fin = 0, d_fin = 0;
    logic             h_mreq = 0, e_mreq = 0, d_mreq = 0;
    logic             cmd_stall, h_start, e_start, d_start;
    logic [IDX_W-1:0] eng_index;
    logic             h_mgnt, e_mgnt, d_mgnt, H_done, E_done, D_done, busy, cmd_err;

    int checks = 0;
    int errors = 0;

    accel_sched #(.FIFO_DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .H_int(H_int), .E_int(E_int), .D_int(D_int), .index(index),
        .cmd_stall(cmd_stall),
        .h_start(h_start), .e_start(e_start), .d_start(d_start), .eng_index(eng_index),
        .h_fin(h_fin), .e_fin(e_fin), .d_fin(d_fin),
        .h_mreq(h_mreq), .e_mreq(e_mreq), .d_mreq(d_mreq),
        .h_mgnt(h_mgnt), .e_mgnt(e_mgnt), .d_mgnt(d_mgnt),
        .H_done(H_done), .E_done(E_done), .D_done(D_done),
        .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0]       t;
        logic [IDX_W-1:0] idx;
    } ent_t;

    ent_t             q[$];
    logic [2:0]       mbusy;
    int               holder;
    int               mlast;
    logic [2:0]       x_start, x_done, x_gnt;
    logic [IDX_W-1:0] x_idx;
    logic             x_busy, x_stall, x_err;

    function automatic void model_reset();
        q.delete();
        mbusy   = 3'b000;
        holder  = -1;
        mlast   = 2;
        x_start = 3'b000;
        x_done  = 3'b000;
        x_gnt   = 3'b000;
        x_idx   = '0;
        x_busy  = 1'b0;
        x_stall = 1'b0;
        x_err   = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [2:0] ints  = {D_int, E_int, H_int};
        logic [2:0] fins  = {d_fin, e_fin, h_fin};
        logic [2:0] mreqs = {d_mreq, e_mreq, h_mreq};
        bit         was_full = (q.size() == DEPTH);
        int         started = -1;
        ent_t       n;
        x_start = 3'b000;
        if (q.size() > 0 && !mbusy[q[0].t]) begin
            started          = int'(q[0].t);
            x_start[q[0].t]  = 1'b1;
            x_idx            = q[0].idx;
            void'(q.pop_front());
        end
        x_done = fins & mbusy;
        mbusy  = mbusy & ~fins;
        if (started >= 0) mbusy[started] = 1'b1;
        if (ints != 3'b000 && !was_full) begin
            n.t   = ints[0] ? 2'd0 : (ints[1] ? 2'd1 : 2'd2);
            n.idx = index;
            q.push_back(n);
        end
        x_err   = ($countones(ints) > 1);
        x_stall = (q.size() == DEPTH);
        x_busy  = (q.size() > 0) || (mbusy != 3'b000);
        if (holder < 0 || !mreqs[holder]) begin
            int nh = -1;
            for (int k = 1; k <= 3; k++) begin
                int c = (mlast + k) % 3;
                if (nh < 0 && mreqs[c]) nh = c;
            end
            holder = nh;
            if (nh >= 0) mlast = nh;
        end
        x_gnt = (holder >= 0) ? (3'b001 << holder) : 3'b000;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", name, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("cmd_stall", 32'(cmd_stall), 32'(x_stall));
        chk("start", 32'({d_start, e_start, h_start}), 32'(x_start));
        if (x_start != 3'b000) chk("eng_index", 32'(eng_index), 32'(x_idx));
        chk("done", 32'({D_done, E_done, H_done}), 32'(x_done));
        chk("mgnt", 32'({d_mgnt, e_mgnt, h_mgnt}), 32'(x_gnt));
        chk("busy", 32'(busy), 32'(x_busy));
        chk("cmd_err", 32'(cmd_err), 32'(x_err));
    endtask

    // one clock: model follows the edge, outputs checked 1 time unit later, inputs change at negedge
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic set_int(input logic h, input logic e, input logic d, input logic [IDX_W-1:0] ix);
        H_int = h; E_int = e; D_int = d; index = ix;
    endtask

    initial begin
        model_reset();
        #2 rst = 1'b1;
        #1 compare_all();
        step();
        step();
        rst = 1'b0;

        // single H command
        set_int(1, 0, 0, 11'h155);
        step();
        set_int(0, 0, 0, 11'h000);
        step();
        chk("single_h_start", 32'(h_start), 32'd1);
        chk("single_h_index", 32'(eng_index), 32'h155);
        step();
        step();
        h_fin = 1'b1;
        step();
        h_fin = 1'b0;
        chk("single_h_done", 32'(H_done), 32'd1);
        step();
        chk("single_h_idle", 32'(busy), 32'd0);

        // queue full: E engine occupied, four more queued, sixth dropped
        for (int i = 0; i < 6; i++) begin
            set_int(0, 1, 0, 11'(12'h100 + i));
            step();
        end
        set_int(0, 0, 0, 11'h000);
        chk("full_stall", 32'(cmd_stall), 32'd1);
        step();
        for (int i = 0; i < 6; i++) begin
            e_fin = 1'b1;
            step();
            e_fin = 1'b0;
            step();
            step();
        end
        chk("full_drained", 32'(busy), 32'd0);

        // head-of-line blocking
        set_int(0, 1, 0, 11'h00F); step();
        set_int(0, 1, 0, 11'h010); step();
        set_int(0, 0, 1, 11'h020); step();
        set_int(0, 0, 0, 11'h000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hol_no_d_start", 32'(d_start), 32'd0);
        end
        e_fin = 1'b1; step();
        e_fin = 1'b0; step();
        chk("hol_e_start", 32'(e_start), 32'd1);
        step();
        chk("hol_d_start", 32'(d_start), 32'd1);
        chk("hol_d_index", 32'(eng_index), 32'h020);
        e_fin = 1'b1; d_fin = 1'b1; step();
        e_fin = 1'b0; d_fin = 1'b0; step();

        // multi-hot request
        set_int(1, 1, 0, 11'h7FF); step();
        chk("multi_err", 32'(cmd_err), 32'd1);
        set_int(0, 0, 0, 11'h000); step();
        chk("multi_err_once", 32'(cmd_err), 32'd0);
        chk("multi_h_index", 32'(eng_index), 32'h7FF);
        step();
        h_fin = 1'b1; step();
        h_fin = 1'b0; step();
        step();
        chk("multi_no_e", 32'(busy), 32'd0);

        // arbiter rotation with back-to-back handover
        h_mreq = 1'b1; e_mreq = 1'b1; d_mreq = 1'b1;
        step(); chk("arb_first_h", 32'({d_mgnt, e_mgnt, h_mgnt}), 32'b001);
        step(); step();
        h_mreq = 1'b0;
        step(); chk("arb_then_e", 32'({d_mgnt, e_mgnt, h_mgnt}), 32'b010);
        step(); step();
        e_mreq = 1'b0;
        step(); chk("arb_then_d", 32'({d_mgnt, e_mgnt, h_mgnt}), 32'b100);
        step(); step();
        d_mreq = 1'b0;
        step(); chk("arb_idle", 32'({d_mgnt, e_mgnt, h_mgnt}), 32'b000);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            H_int  = ($urandom_range(0, 5) == 0);
            E_int  = ($urandom_range(0, 5) == 0);
            D_int  = ($urandom_range(0, 5) == 0);
            index  = 11'($urandom);
            h_fin  = ($urandom_range(0, 4) == 0);
            e_fin  = ($urandom_range(0, 4) == 0);
            d_fin  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) h_mreq = ~h_mreq;
            if ($urandom_range(0, 3) == 0) e_mreq = ~e_mreq;
            if ($urandom_range(0, 3) == 0) d_mreq = ~d_mreq;
            step();
        end
        set_int(0, 0, 0, 11'h000);
        h_mreq = 1'b0; e_mreq = 1'b0; d_mreq = 1'b0;
        for (int i = 0; i < 12; i++) begin
            h_fin = 1'b1; e_fin = 1'b1; d_fin = 1'b1;
            step();
        end
        h_fin = 1'b0; e_fin = 1'b0; d_fin = 1'b0;
        step();

        // reset mid-run with E busy and two commands queued
        set_int(0, 1, 0, 11'h0AA); step();
        set_int(0, 1, 0, 11'h0AB); step();
        set_int(0, 0, 1, 11'h0AC); step();
        set_int(0, 0, 0, 11'h000);
        h_mreq = 1'b1;
        step();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        model_reset();
        #1 compare_all();
        step();
        rst    = 1'b0;
        h_mreq = 1'b0;
        e_fin  = 1'b1;
        step();
        chk("post_reset_no_done", 32'(E_done), 32'd0);
        e_fin = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
